// File: rtl/conv_window_mac.sv
// Serial windowed multiply-accumulate behind the circular sample buffer: one tap per cycle, valid/ready result.
// Optional build macro CONV_RELU_EN clamps negative dot products to zero when the result is loaded.
module conv_window_mac #(
    parameter int Buffer_size = 24,
    parameter int N           = 8,
    parameter int ACC_W       = 20,
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    win_valid,
    output logic                    win_ready,
    input  logic [7:0]              win_base,
    output logic [7:0]              read_addr [0:N-1],
    input  logic [7:0]              read_data [0:N-1],
    input  logic                    coef_we,
    input  logic [IDX_W-1:0]        coef_idx,
    input  logic [7:0]              coef_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    bad_base
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]              state;
    logic [7:0]              base_reg;
    logic [IDX_W-1:0]        k;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] result;
    logic signed [7:0]       coef [0:N-1];
    logic [8:0]              addr_sum [0:N-1];
    logic signed [16:0]      product;
    logic                    base_ok;

    assign win_ready = (state == S_IDLE);
    assign out_valid = (state == S_OUT);

    always_comb begin
        base_ok = ({1'b0, win_base} < 9'(Buffer_size));
    end

    // base_reg < Buffer_size and i < N <= Buffer_size, so one conditional subtract wraps correctly
    always_comb begin
        for (int i = 0; i < N; i++) begin
            addr_sum[i] = {1'b0, base_reg} + 9'(i);
            if (addr_sum[i] >= 9'(Buffer_size))
                read_addr[i] = 8'(addr_sum[i] - 9'(Buffer_size));
            else
                read_addr[i] = addr_sum[i][7:0];
        end
    end

    always_comb begin
        product  = $signed({1'b0, read_data[k]}) * coef[k];
        acc_next = acc + ACC_W'(product);
`ifdef CONV_RELU_EN
        result   = acc_next[ACC_W-1] ? '0 : acc_next;
`else
        result   = acc_next;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            base_reg <= '0;
            k        <= '0;
            acc      <= '0;
            out_data <= '0;
            bad_base <= 1'b0;
        end else begin
            bad_base <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        if (base_ok) begin
                            base_reg <= win_base;
                            acc      <= '0;
                            k        <= '0;
                            state    <= S_ACC;
                        end else begin
                            bad_base <= 1'b1;
                        end
                    end
                end
                S_ACC: begin
                    acc <= acc_next;
                    k   <= k + 1'b1;
                    if (k == IDX_W'(N - 1)) begin
                        out_data <= result;
                        state    <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Kernel is frozen outside IDLE so every window sees one consistent set of taps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                coef[i] <= '0;
        end else if (coef_we && state == S_IDLE) begin
            coef[coef_idx] <= coef_data;
        end
    end

endmodule

// File: tb/tb_conv_window_mac.sv
// Self-checking bench for conv_window_mac: directed and random windows against a modular-arithmetic dot-product model.
module tb_conv_window_mac;

    localparam int BS    = 24;
    localparam int N     = 8;
    localparam int ACC_W = 20;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    win_valid;
    logic                    win_ready;
    logic [7:0]              win_base;
    logic [7:0]              read_addr [0:N-1];
    logic [7:0]              read_data [0:N-1];
    logic                    coef_we;
    logic [2:0]              coef_idx;
    logic [7:0]              coef_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic                    bad_base;

    logic [7:0]              mem [0:BS-1];
    int                      coefM [0:N-1];
    int                      nChecks = 0;
    int                      nFails = 0;

    conv_window_mac #(.Buffer_size(BS), .N(N), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .win_valid(win_valid), .win_ready(win_ready), .win_base(win_base),
        .read_addr(read_addr), .read_data(read_data),
        .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .bad_base(bad_base)
    );

    always #5 clk = ~clk;

    // Combinational sample buffer model
    always_comb begin
        for (int i = 0; i < N; i++)
            read_data[i] = (int'(read_addr[i]) < BS) ? mem[read_addr[i]] : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int modelDot(input int base);
        int sum = 0;
        logic signed [ACC_W-1:0] r;
        for (int i = 0; i < N; i++)
            sum += int'(mem[(base + i) % BS]) * coefM[i];
        r = sum[ACC_W-1:0];
`ifdef CONV_RELU_EN
        if (r < 0) r = '0;
`endif
        return int'(r);
    endfunction

    task automatic writeCoef(input int idx, input int val);
        coef_we   = 1'b1;
        coef_idx  = 3'(idx);
        coef_data = 8'(val);
        tick();
        coef_we   = 1'b0;
        coefM[idx] = int'($signed(8'(val)));
    endtask

    // Offers a window, checks addresses, latency and result; leaves the DUT in OUT
    task automatic applyStimulus(input int base, input bit pokeCoef);
        int cycles;
        int expected;
        win_valid = 1'b1;
        win_base  = 8'(base);
        cycles = 0;
        while (!win_ready && cycles < 50) begin
            tick();
            cycles++;
        end
        checkOutput("accept_wait", int'(win_ready), 1);
        tick();
        win_valid = 1'b0;
        expected = modelDot(base);
        for (int i = 0; i < N; i++)
            checkOutput($sformatf("read_addr[%0d]", i), int'(read_addr[i]), (base + i) % BS);
        checkOutput("win_ready_acc", int'(win_ready), 0);
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            if (pokeCoef && cycles == 0) begin
                coef_we   = 1'b1;
                coef_idx  = 3'd0;
                coef_data = 8'(coefM[0] + 37);
            end
            tick();
            coef_we = 1'b0;
            cycles++;
        end
        checkOutput("latency", cycles, N);
        checkOutput($sformatf("out_data base=%0d", base), int'(out_data), expected);
        checkOutput("win_ready_out", int'(win_ready), 0);
    endtask

    task automatic finishWindow();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("out_valid_after_hs", int'(out_valid), 0);
        checkOutput("win_ready_after_hs", int'(win_ready), 1);
    endtask

    initial begin
        int base2;
        int held;
        rst = 1'b1;
        win_valid = 1'b0;
        win_base = '0;
        coef_we = 1'b0;
        coef_idx = '0;
        coef_data = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) coefM[i] = 0;
        for (int a = 0; a < BS; a++) mem[a] = 8'(a + 1);
        #1;
        checkOutput("rst_win_ready", int'(win_ready), 1);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_bad_base", int'(bad_base), 0);
        for (int i = 0; i < N; i++)
            checkOutput($sformatf("rst_read_addr[%0d]", i), int'(read_addr[i]), i);
        tick();
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] all-ones kernel, buffer 1..24, base 0");
        for (int i = 0; i < N; i++) writeCoef(i, 1);
        applyStimulus(0, 1'b0);
        checkOutput("sum_1_to_8", int'(out_data), 36);
        finishWindow();

        $display("[TB] wrap-around window at base 20");
        for (int a = 0; a < BS; a++) mem[a] = 8'(a);
        applyStimulus(20, 1'b0);
        checkOutput("wrap_sum", int'(out_data), 92);
        finishWindow();

        $display("[TB] most negative product");
        writeCoef(0, -128);
        for (int i = 1; i < N; i++) writeCoef(i, 0);
        mem[0] = 8'd255;
        applyStimulus(0, 1'b0);
`ifdef CONV_RELU_EN
        checkOutput("neg_product", int'(out_data), 0);
`else
        checkOutput("neg_product", int'(out_data), -32640);
`endif
        finishWindow();

        $display("[TB] back-pressure with a queued window");
        for (int i = 0; i < N; i++) writeCoef(i, int'($urandom_range(0, 255)));
        for (int a = 0; a < BS; a++) mem[a] = 8'($urandom_range(0, 255));
        applyStimulus(int'($urandom_range(0, BS - 1)), 1'b0);
        held = int'(out_data);
        base2 = int'($urandom_range(0, BS - 1));
        win_valid = 1'b1;
        win_base = 8'(base2);
        for (int c = 0; c < 10; c++) begin
            tick();
            checkOutput("stall_out_valid", int'(out_valid), 1);
            checkOutput("stall_out_data", int'(out_data), held);
            checkOutput("stall_win_ready", int'(win_ready), 0);
        end
        finishWindow();
        applyStimulus(base2, 1'b0);
        finishWindow();

        $display("[TB] random kernels and windows");
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) writeCoef(i, int'($urandom_range(0, 255)));
            for (int a = 0; a < BS; a++) mem[a] = 8'($urandom_range(0, 255));
            applyStimulus(int'($urandom_range(0, BS - 1)), 1'b0);
            finishWindow();
        end

        $display("[TB] coefficient write during accumulation is ignored");
        applyStimulus(int'($urandom_range(0, BS - 1)), 1'b1);
        finishWindow();
        applyStimulus(3, 1'b0);
        finishWindow();

        $display("[TB] out-of-range base");
        win_valid = 1'b1;
        win_base = 8'd30;
        tick();
        win_valid = 1'b0;
        checkOutput("bad_base_pulse", int'(bad_base), 1);
        checkOutput("bad_win_ready", int'(win_ready), 1);
        tick();
        checkOutput("bad_base_clear", int'(bad_base), 0);
        for (int c = 0; c < N + 2; c++) begin
            checkOutput("bad_no_result", int'(out_valid), 0);
            tick();
        end
        checkOutput("bad_base_once", int'(bad_base), 0);
        applyStimulus(4, 1'b0);
        finishWindow();

        $display("[TB] reset mid-window");
        win_valid = 1'b1;
        win_base = 8'd5;
        tick();
        win_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", int'(out_valid), 0);
        checkOutput("midrst_win_ready", int'(win_ready), 1);
        checkOutput("midrst_out_data", int'(out_data), 0);
        checkOutput("midrst_read_addr0", int'(read_addr[0]), 0);
        for (int i = 0; i < N; i++) coefM[i] = 0;
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(int'($urandom_range(0, BS - 1)), 1'b0);
        checkOutput("post_rst_zero", int'(out_data), 0);
        finishWindow();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/conv_window_mac.md
# conv_window_mac

Serial multiply-accumulate stage that sits directly downstream of the circular sample buffer in the streaming convolution datapath. For each accepted window it drives the buffer's N read addresses, starting at a window base address with wrap-around. It accumulates one tap per cycle against a programmable signed kernel and presents the dot product on a valid/ready output. Upstream, the stream writer supplies window base addresses; downstream, the result feeds the output stream.

## Interface
- Buffer_size, 24: depth of the sample buffer in bytes; address modulus. Must satisfy N ≤ Buffer_size ≤ 256.
- N, 8: taps per window; equals the buffer's read-port count.
- ACC_W, 20: signed accumulator and result width. Must be ≥ 17 + clog2(N).
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- win_valid, input, 1: a window base is offered.
- win_ready, output, 1: block can accept a window; high only in IDLE.
- win_base, input, 8: buffer address of tap 0 of the offered window.
- read_addr[0:N-1], output, 8 each: to buffer read ports.
- read_data[0:N-1], input, 8 each: unsigned samples, combinational from buffer.
- coef_we, input, 1: kernel coefficient write strobe.
- coef_idx, input, clog2(N): coefficient index.
- coef_data, input, 8: signed coefficient value.
- out_valid, output, 1: result available.
- out_ready, input, 1: downstream accepts result.
- out_data, output, ACC_W: signed dot-product result.
- bad_base, output, 1: one-cycle pulse when a window with out-of-range base is consumed.

## Operation
- States: IDLE, ACC, OUT.
- IDLE:
  - win_ready=1.
  - On win_valid with win_base < Buffer_size: latch base_reg=win_base, clear acc, set k=0, go to ACC.
  - On win_valid with win_base ≥ Buffer_size: consume the window, pulse bad_base next cycle, stay in IDLE, produce no result.
- Addressing:
  - read_addr[i] = base_reg+i, minus Buffer_size if that sum is ≥ Buffer_size.
  - One conditional subtract only; valid because base_reg < Buffer_size and i < N ≤ Buffer_size.
  - Addresses are driven from the registered base_reg in every state.
- ACC: each cycle acc += zero-extend(read_data[k]) × sign-extend(coef[k]), with a 17-bit signed product sign-extended to ACC_W. k increments; after tap N-1, load out_data with the final sum and go to OUT.
- OUT:
  - out_valid=1; out_data holds stable until out_valid && out_ready, then go to IDLE.
  - Back-pressure stalls indefinitely.
- Coefficients: N×8-bit signed registers, reset to 0. coef_we writes coef[coef_idx] only in IDLE; writes in ACC or OUT are ignored, so a window always uses one consistent kernel.
- Arithmetic wraps at ACC_W bits; no saturation (default sizing cannot overflow: 8×255×128 < 2^19).
- Reset mid-window: state→IDLE, acc, out_data, base_reg, k and coef all cleared; outputs return to reset values immediately.

## Timing
- Reset values:
  - win_ready=1, out_valid=0, out_data=0, bad_base=0.
  - read_addr[i]=i.
- A window accepted at edge E0 produces out_valid high after edge E0+N: N+1 cycles from the first win_valid cycle when already in IDLE.
- Tap k uses read_data[k] sampled at edge E0+1+k. The buffer must not overwrite the window's addresses during that period.
- Minimum window period: N+2 cycles (accept, N taps, OUT with out_ready=1, return to IDLE).
- win_valid arriving during ACC or OUT is held off by win_ready=0; no window is dropped.
- bad_base is high for exactly one cycle, the cycle after consumption.

## Configuration
- CONV_RELU_EN:
  - Defined: the value loaded into out_data is max(sum, 0), so negative dot products present as 0.
  - Undefined: out_data is the raw signed sum.
  - Accumulation, latency and handshakes are identical in both cases.

## Test plan
- Reset, then all coef=1, buffer holds 1..24, win_base=0 → out_valid after N+1 cycles, out_data=36; read_addr=0..7 during ACC.
- win_base=20, coef=1, buffer addr=value → read_addr=20,21,22,23,0,1,2,3; out_data=92.
- coef[0]=-128, others 0, read_data[0]=255 → out_data=-32640 without CONV_RELU_EN; 0 with it.
- Hold out_ready=0 for 10 cycles → out_valid and out_data stable; win_ready=0; a second window offered is accepted only after the out_ready handshake.
- win_base=30 → bad_base pulses once, no out_valid; the next window with win_base=4 completes normally.
- Assert rst during ACC at k=3 → out_valid=0, win_ready=1 immediately; coef cleared, so the next window yields out_data=0. A coef_we issued during ACC leaves the coefficient unchanged.
